// File: rtl/coin_accumulator.sv
// coin_accumulator: counts Rs.1 / Rs.2 coin pulses, freezes them for the vending
//   controller on a drink request, and refunds on cancel or controller timeout.
// Latency: every event is visible on the registered outputs one cycle after it is
//   sampled.
// Backpressure: none. Coins that cannot be counted are dropped and flagged on
//   coin_reject.
//
// Ports:
//   clk, rst              - rising-edge clock, asynchronous active-high reset
//   coin_re1, coin_rs2    - one-cycle coin-accepted pulses from the validator
//   request, drink_sel    - drink button pulse and tea(0)/coffee(1) select
//   cancel                - user refund button pulse
//   vend_done             - controller dispensed; consumes the held credit
//   re1, rs2, credit      - coin counts and total value presented to the controller
//   drink, enable         - latched select; counts frozen and valid while enable=1
//   coin_reject           - pulse when a coin pulse was seen but not counted
//   refund, refund_re1/_rs2 - one-cycle refund pulse with the coins to return

module coin_accumulator #(
    parameter int RE1_MAX = 15,
    parameter int RS2_MAX = 7,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_re1,
    input  logic       coin_rs2,
    input  logic       request,
    input  logic       drink_sel,
    input  logic       cancel,
    input  logic       vend_done,
    output logic [3:0] re1,
    output logic [2:0] rs2,
    output logic       drink,
    output logic       enable,
    output logic [4:0] credit,
    output logic       coin_reject,
    output logic       refund,
    output logic [3:0] refund_re1,
    output logic [2:0] refund_rs2
);

    // Timeout counter only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   tcnt;

    // Combinational view of the coin-counting step used in IDLE and COLLECT.
    logic            re1_full;
    logic            rs2_full;
    logic            re1_take;
    logic            rs2_take;
    logic [3:0]      re1_nxt;
    logic [2:0]      rs2_nxt;
    logic            sat_reject;
    logic            any_coin;
    logic            time_up;

    function automatic logic [4:0] credit_of(input logic [3:0] a, input logic [2:0] b);
        return {1'b0, a} + {1'b0, b, 1'b0};
    endfunction

    always_comb begin
        re1_full   = (re1 == 4'(RE1_MAX));
        rs2_full   = (rs2 == 3'(RS2_MAX));
        re1_take   = coin_re1 && !re1_full;
        rs2_take   = coin_rs2 && !rs2_full;
        re1_nxt    = re1 + {3'b000, re1_take};
        rs2_nxt    = rs2 + {2'b00, rs2_take};
        // A saturated count drops the coin; the other coin of the same cycle
        // may still be counted.
        sat_reject = (coin_re1 && re1_full) || (coin_rs2 && rs2_full);
        any_coin   = coin_re1 || coin_rs2;
        time_up    = (tcnt == TCNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            re1         <= '0;
            rs2         <= '0;
            drink       <= 1'b0;
            enable      <= 1'b0;
            credit      <= '0;
            coin_reject <= 1'b0;
            refund      <= 1'b0;
            refund_re1  <= '0;
            refund_rs2  <= '0;
        end else begin
            // Refund outputs are single-cycle; only the entry into REFUND sets them.
            refund     <= 1'b0;
            refund_re1 <= '0;
            refund_rs2 <= '0;

            case (state)
                S_IDLE: begin
                    // request/cancel are meaningless with nothing inserted.
                    coin_reject <= sat_reject;
                    re1         <= re1_nxt;
                    rs2         <= rs2_nxt;
                    credit      <= credit_of(re1_nxt, rs2_nxt);
                    if (re1_take || rs2_take) begin
                        state <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    // Coins in the same cycle as request/cancel are included.
                    coin_reject <= sat_reject;
                    re1         <= re1_nxt;
                    rs2         <= rs2_nxt;
                    credit      <= credit_of(re1_nxt, rs2_nxt);
                    if (cancel) begin
                        state      <= S_REFUND;
                        refund     <= 1'b1;
                        refund_re1 <= re1_nxt;
                        refund_rs2 <= rs2_nxt;
                    end else if (request) begin
                        state  <= S_PRESENT;
                        drink  <= drink_sel;
                        enable <= 1'b1;
                        tcnt   <= '0;
                    end
                end

                S_PRESENT: begin
                    // Counts are frozen; any coin now is bounced.
                    coin_reject <= any_coin;
                    if (vend_done) begin
                        state  <= S_IDLE;
                        re1    <= '0;
                        rs2    <= '0;
                        credit <= '0;
                        drink  <= 1'b0;
                        enable <= 1'b0;
                        tcnt   <= '0;
                    end else if (cancel || time_up) begin
                        state      <= S_REFUND;
                        enable     <= 1'b0;
                        refund     <= 1'b1;
                        refund_re1 <= re1;
                        refund_rs2 <= rs2;
                        tcnt       <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_REFUND: begin
                    // Counts stay visible during the refund cycle, then clear.
                    coin_reject <= any_coin;
                    state       <= S_IDLE;
                    re1         <= '0;
                    rs2         <= '0;
                    credit      <= '0;
                    drink       <= 1'b0;
                    enable      <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
